// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: register-level I2C transaction sequencer.
// Turns one register read/write request into the ordered byte ops of the
// downstream byte engine (START+addr, reg addr, repeated START, data, STOP),
// aborts with a stop-only op on an address/register NACK, and guards every
// byte op with a saturating watchdog (TIMEOUT_CYC = 0 disables it).
// Build option: define I2C_REG16_EN for 16-bit register addresses (high byte
// first); without it the register address is 8 bits and i_req_reg[15:8] is
// ignored.
// All outputs are registered from the next-state values, so an accept at
// cycle T is visible on o_busy/o_byte_valid at T+1.
module i2c_reg_seq #(
    parameter int unsigned TIMEOUT_CYC = 32'd2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rw,
    input  logic [6:0]  i_req_dev,
    input  logic [15:0] i_req_reg,
    input  logic [7:0]  i_req_wdata,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_rd_data,
    output logic        o_busy,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_byte_start,
    output logic        o_byte_wr,
    output logic        o_byte_rd,
    output logic        o_byte_stop,
    output logic [7:0]  o_byte_wdata,
    input  logic        i_byte_done,
    input  logic        i_byte_nack,
    input  logic [7:0]  i_byte_rdata
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ISSUE       = 3'd1,
        S_WAIT        = 3'd2,
        S_ABORT_ISSUE = 3'd3,
        S_ABORT_WAIT  = 3'd4,
        S_FIN         = 3'd5
    } state_t;

    // Byte op packing: {start, wr, rd, stop, data[7:0]}
    localparam logic [11:0] OP_NONE  = 12'h000;
    localparam logic [11:0] OP_ABORT = {4'b0001, 8'hFF};

`ifdef I2C_REG16_EN
    localparam logic REG16 = 1'b1;
    logic [7:0] reg_hi_s;
    assign reg_hi_s = i_req_reg[15:8];
`else
    localparam logic REG16 = 1'b0;
    logic [7:0] reg_hi_s;
    logic       unused_reg_hi_s;
    assign reg_hi_s        = 8'h00;
    assign unused_reg_hi_s = ^i_req_reg[15:8];
`endif

    // Step 0 dev+W, 1 reg hi, 2 reg lo, 3 data (write) or dev+R (read), 4 read byte.
    function automatic logic [11:0] op_decode(input logic [2:0] step, input logic rw,
                                              input logic [6:0] dev, input logic [15:0] rg,
                                              input logic [7:0] wd);
        logic [11:0] op;
        case (step)
            3'd0:    op = {4'b1100, dev, 1'b0};
            3'd1:    op = {4'b0100, rg[15:8]};
            3'd2:    op = {4'b0100, rg[7:0]};
            3'd3:    op = rw ? {4'b1100, dev, 1'b1} : {4'b0101, wd};
            3'd4:    op = {4'b0011, 8'hFF};
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        rw_q, rw_d;
    logic [6:0]  dev_q, dev_d;
    logic [15:0] reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] wdog_q, wdog_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic [11:0] out_op_q, out_op_d;
    logic        byte_valid_q, byte_valid_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_out_q, err_out_d;

    logic        op_is_rd_s;
    logic        op_has_stop_s;
    logic        last_step_s;
    logic        timeout_s;
    logic [2:0]  step_next_s;
    logic [31:0] wdog_inc_s;

    assign op_is_rd_s    = (step_q == 3'd4);
    assign op_has_stop_s = op_is_rd_s || ((step_q == 3'd3) && !rw_q);
    assign last_step_s   = rw_q ? (step_q == 3'd4) : (step_q == 3'd3);
    assign step_next_s   = (!REG16 && (step_q == 3'd0)) ? 3'd2 : (step_q + 3'd1);
    assign wdog_inc_s    = (wdog_q == 32'hFFFF_FFFF) ? wdog_q : (wdog_q + 32'd1);
    assign timeout_s     = (TIMEOUT_CYC != 32'd0) && (wdog_q >= (TIMEOUT_CYC - 32'd1));

    // State and context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= 3'd0;
            rw_q      <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 16'd0;
            wdata_q   <= 8'd0;
            err_q     <= 1'b0;
            wdog_q    <= 32'd0;
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            wdog_q    <= wdog_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next-state and context update logic.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        wdog_d    = wdog_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid && ready_q) begin
                    rw_d    = i_req_rw;
                    dev_d   = i_req_dev;
                    reg_d   = {reg_hi_s, i_req_reg[7:0]};
                    wdata_d = i_req_wdata;
                    step_d  = 3'd0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (i_byte_ready) begin
                    wdog_d  = 32'd0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (i_byte_done) begin
                    if (op_is_rd_s) begin
                        rd_data_d = i_byte_rdata;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    if (!op_is_rd_s && i_byte_nack) begin
                        err_d   = 1'b1;
                        state_d = op_has_stop_s ? S_FIN : S_ABORT_ISSUE;
                    end else if (last_step_s) begin
                        state_d = S_FIN;
                    end else begin
                        step_d  = step_next_s;
                        state_d = S_ISSUE;
                    end
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wdog_d  = wdog_inc_s;
                end
            end
            S_ABORT_ISSUE: begin
                if (i_byte_ready) begin
                    wdog_d  = 32'd0;
                    state_d = S_ABORT_WAIT;
                end else begin
                    state_d = S_ABORT_ISSUE;
                end
            end
            S_ABORT_WAIT: begin
                if (i_byte_done) begin
                    state_d = S_FIN;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wdog_d  = wdog_inc_s;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values derived from the next state, registered below.
    always_comb begin
        byte_valid_d = 1'b0;
        out_op_d     = OP_NONE;
        if (state_d == S_ISSUE) begin
            byte_valid_d = 1'b1;
            out_op_d     = op_decode(step_d, rw_d, dev_d, reg_d, wdata_d);
        end else if (state_d == S_ABORT_ISSUE) begin
            byte_valid_d = 1'b1;
            out_op_d     = OP_ABORT;
        end else begin
            byte_valid_d = 1'b0;
            out_op_d     = OP_NONE;
        end
        busy_d    = (state_d != S_IDLE);
        ready_d   = (state_d == S_IDLE);
        done_d    = (state_d == S_FIN);
        err_out_d = (state_d == S_FIN) && err_d;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_op_q     <= OP_NONE;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            err_out_q    <= 1'b0;
        end else begin
            out_op_q     <= out_op_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_out_q    <= err_out_d;
        end
    end

    assign o_req_ready  = ready_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_out_q;
    assign o_rd_data    = rd_data_q;
    assign o_byte_valid = byte_valid_q;
    assign o_byte_start = out_op_q[11];
    assign o_byte_wr    = out_op_q[10];
    assign o_byte_rd    = out_op_q[9];
    assign o_byte_stop  = out_op_q[8];
    assign o_byte_wdata = out_op_q[7:0];

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: table of directed transactions with
// hand-computed op sequences, plus hand-written timeout and mid-read reset
// sequences. Ops are written as {start, wr, rd, stop, data}.
module tb_i2c_reg_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_rw;
    logic [6:0]  i_req_dev;
    logic [15:0] i_req_reg;
    logic [7:0]  i_req_wdata;
    logic        o_req_ready, o_done, o_err, o_busy;
    logic [7:0]  o_rd_data;
    logic        o_byte_valid, i_byte_ready;
    logic        o_byte_start, o_byte_wr, o_byte_rd, o_byte_stop;
    logic [7:0]  o_byte_wdata;
    logic        i_byte_done, i_byte_nack;
    logic [7:0]  i_byte_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_reg_seq #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_rw(i_req_rw), .i_req_dev(i_req_dev), .i_req_reg(i_req_reg),
        .i_req_wdata(i_req_wdata),
        .o_done(o_done), .o_err(o_err), .o_rd_data(o_rd_data), .o_busy(o_busy),
        .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
        .o_byte_start(o_byte_start), .o_byte_wr(o_byte_wr), .o_byte_rd(o_byte_rd),
        .o_byte_stop(o_byte_stop), .o_byte_wdata(o_byte_wdata),
        .i_byte_done(i_byte_done), .i_byte_nack(i_byte_nack), .i_byte_rdata(i_byte_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rw;
        logic [6:0]       dev;
        logic [15:0]      rg;
        logic [7:0]       wd;
        int               nack_op;
        logic [7:0]       rdat;
        int               nops;
        logic [0:4][11:0] ops;
        logic             exp_err;
        logic [7:0]       exp_rd;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] cur_op();
        return {o_byte_start, o_byte_wr, o_byte_rd, o_byte_stop, o_byte_wdata};
    endfunction

    task automatic drive_req(input logic rw, input logic [6:0] dev, input logic [15:0] rg,
                             input logic [7:0] wd);
        i_req_valid = 1'b1; i_req_rw = rw; i_req_dev = dev; i_req_reg = rg; i_req_wdata = wd;
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    // Handshake the currently offered op, then complete it after one idle cycle.
    task automatic serve_op(input string tag, input logic nack, input logic [7:0] rd);
        i_byte_ready = 1'b1;
        @(negedge clk);
        i_byte_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, o_byte_valid}, 32'd0);
        @(negedge clk);
        i_byte_done = 1'b1; i_byte_nack = nack; i_byte_rdata = rd;
        @(negedge clk);
        i_byte_done = 1'b0; i_byte_nack = 1'b0; i_byte_rdata = 8'h00;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          nops;
        int          cyc;
        logic        got;
        logic [11:0] op;
        string       tag;
        tag = $sformatf("v%0d", idx);
        chk({tag, "_pre_ready"}, {31'd0, o_req_ready}, 32'd1);
        drive_req(v.rw, v.dev, v.rg, v.wd);
        chk({tag, "_accept"}, {29'd0, o_busy, o_byte_valid, o_req_ready}, 32'b110);
        nops = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            if (o_done) begin
                got = 1'b1;
                chk({tag, "_err"}, {31'd0, o_err}, {31'd0, v.exp_err});
                chk({tag, "_rd_data"}, {24'd0, o_rd_data}, {24'd0, v.exp_rd});
                chk({tag, "_nops"}, nops, v.nops);
                @(negedge clk);
                chk({tag, "_back_idle"}, {29'd0, o_busy, o_req_ready, o_done}, 32'b010);
            end else if (o_byte_valid) begin
                op = cur_op();
                if (nops < 5) begin
                    chk($sformatf("%s_op%0d", tag, nops), {20'd0, op}, {20'd0, v.ops[nops]});
                end else begin
                    chk({tag, "_extra_op"}, nops, 32'd4);
                end
                // A stray done while the op is still being offered must be ignored.
                i_byte_done = 1'b1; i_byte_nack = 1'b1;
                @(negedge clk);
                i_byte_done = 1'b0; i_byte_nack = 1'b0;
                chk({tag, "_op_hold"}, {19'd0, o_byte_valid, cur_op()}, {19'd0, 1'b1, op});
                serve_op(tag, nops == v.nack_op, v.rdat);
                nops++;
                chk({tag, "_next_resp"}, {31'd0, o_byte_valid | o_done}, 32'd1);
                cyc += 4;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        int   k;
        int   nvalid;
        // Expected data for reads keeps the last read byte across writes/aborts.
`ifdef I2C_REG16_EN
        vecs[0] = '{1'b0, 7'h3C, 16'h1234, 8'hA5, -1, 8'hEE, 4,
                    {12'hC78, 12'h412, 12'h434, 12'h5A5, 12'h000}, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'h3C, 16'h0010, 8'h00, -1, 8'h5A, 5,
                    {12'hC78, 12'h400, 12'h410, 12'hC79, 12'h3FF}, 1'b0, 8'h5A};
        vecs[2] = '{1'b0, 7'h50, 16'h0042, 8'h11, 0, 8'hEE, 2,
                    {12'hCA0, 12'h1FF, 12'h000, 12'h000, 12'h000}, 1'b1, 8'h5A};
        vecs[3] = '{1'b0, 7'h3C, 16'hABCD, 8'h77, 3, 8'hEE, 4,
                    {12'hC78, 12'h4AB, 12'h4CD, 12'h577, 12'h000}, 1'b1, 8'h5A};
        vecs[4] = '{1'b1, 7'h21, 16'h5566, 8'h00, 1, 8'hEE, 3,
                    {12'hC42, 12'h455, 12'h1FF, 12'h000, 12'h000}, 1'b1, 8'h5A};
        vecs[5] = '{1'b1, 7'h7F, 16'h00FF, 8'h00, -1, 8'hC3, 5,
                    {12'hCFE, 12'h400, 12'h4FF, 12'hCFF, 12'h3FF}, 1'b0, 8'hC3};
        vecs[6] = '{1'b1, 7'h3C, 16'h0001, 8'h00, 3, 8'hEE, 5,
                    {12'hC78, 12'h400, 12'h401, 12'hC79, 12'h1FF}, 1'b1, 8'hC3};
`else
        vecs[0] = '{1'b0, 7'h3C, 16'h1234, 8'hA5, -1, 8'hEE, 3,
                    {12'hC78, 12'h434, 12'h5A5, 12'h000, 12'h000}, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'h3C, 16'h0010, 8'h00, -1, 8'h5A, 4,
                    {12'hC78, 12'h410, 12'hC79, 12'h3FF, 12'h000}, 1'b0, 8'h5A};
        vecs[2] = '{1'b0, 7'h50, 16'h0042, 8'h11, 0, 8'hEE, 2,
                    {12'hCA0, 12'h1FF, 12'h000, 12'h000, 12'h000}, 1'b1, 8'h5A};
        vecs[3] = '{1'b0, 7'h3C, 16'hABCD, 8'h77, 2, 8'hEE, 3,
                    {12'hC78, 12'h4CD, 12'h577, 12'h000, 12'h000}, 1'b1, 8'h5A};
        vecs[4] = '{1'b1, 7'h21, 16'h5566, 8'h00, 1, 8'hEE, 3,
                    {12'hC42, 12'h466, 12'h1FF, 12'h000, 12'h000}, 1'b1, 8'h5A};
        vecs[5] = '{1'b1, 7'h7F, 16'h00FF, 8'h00, -1, 8'hC3, 4,
                    {12'hCFE, 12'h4FF, 12'hCFF, 12'h3FF, 12'h000}, 1'b0, 8'hC3};
        vecs[6] = '{1'b1, 7'h3C, 16'h0001, 8'h00, 2, 8'hEE, 4,
                    {12'hC78, 12'h401, 12'hC79, 12'h1FF, 12'h000}, 1'b1, 8'hC3};
`endif

        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_rw = 1'b0; i_req_dev = 7'd0; i_req_reg = 16'd0;
        i_req_wdata = 8'd0; i_byte_ready = 1'b0; i_byte_done = 1'b0; i_byte_nack = 1'b0;
        i_byte_rdata = 8'd0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {o_req_ready, o_busy, o_done, o_err, o_byte_valid, o_byte_start,
                              o_byte_wr, o_byte_rd, o_byte_stop, o_byte_wdata, o_rd_data},
            32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {30'd0, o_req_ready, o_busy}, 32'b10);

        // Table: back-to-back transactions.
        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Watchdog: op 0 is accepted but never completes.
        drive_req(1'b0, 7'h3C, 16'h0001, 8'h55);
        chk("to_first_valid", {31'd0, o_byte_valid}, 32'd1);
        i_byte_ready = 1'b1;
        @(negedge clk);
        i_byte_ready = 1'b0;
        k = 1; nvalid = 0;
        while (!o_done && k < 300) begin
            if (o_byte_valid) nvalid++;
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k < 100 || k > 102) begin
            n_bad++;
            $display("FAIL to_latency: done after %0d cycles, expected 100..102", k);
        end
        chk("to_err", {31'd0, o_err}, 32'd1);
        chk("to_no_stop_op", nvalid, 32'd0);
        @(negedge clk);
        chk("to_back_idle", {30'd0, o_busy, o_req_ready}, 32'b01);

        // Reset in the middle of a read, then a fresh write.
        drive_req(1'b1, 7'h3C, 16'h0010, 8'h00);
        serve_op("rst_op0", 1'b0, 8'h00);
        serve_op("rst_op1", 1'b0, 8'h00);
        chk("rst_pre_valid", {30'd0, o_byte_valid, o_busy}, 32'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", {28'd0, o_byte_valid, o_busy, o_done, o_req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release", {30'd0, o_req_ready, o_busy}, 32'b10);
        run_vec(7, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
